// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// The scheduler FSM and the byte queue both import from here.
package uart_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int CLKS_PER_BIT_DEF = 217;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } tx_sched_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte queue: storage, wrapping pointers, occupancy count, and an overflow pulse.
// A write while full is dropped, even when a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  input  logic                       i_rd_en,
  output logic [DATA_WIDTH-1:0]      o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  w_push;
  logic                  w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_rd_data  = r_mem[r_rd_ptr];

  assign w_push = i_wr_en && !o_full;
  assign w_pop  = i_rd_en && !o_empty;

  // Storage needs no reset; stale entries are never visible because count gates reads.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_wr_en && o_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Byte queue plus launch sequencer feeding the UART transmitter, one launch per byte.
// Waits for the transmitter's done before launching the next byte; a watchdog abandons a launch whose done never arrives.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [DATA_WIDTH-1:0]  i_wr_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic                   o_tx_data_valid,
  output logic [DATA_WIDTH-1:0]  o_tx_data,
  input  logic                   i_tx_active,
  input  logic                   i_tx_done,
  output logic                   o_tx_timeout,
  output logic                   o_busy
);

  localparam int WDW = $clog2(TIMEOUT_CLKS);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CLKS - 1);

  tx_sched_state_t       r_state;
  tx_sched_state_t       w_state_nxt;
  logic [WDW-1:0]        r_wd;
  logic                  r_tx_data_valid;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_timeout;
  logic                  w_launch;
  logic                  w_timeout;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_rd_en    (w_launch),
    .o_rd_data  (w_head),
    .o_full     (o_full),
    .o_empty    (w_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  assign o_empty         = w_empty;
  assign o_tx_data_valid = r_tx_data_valid;
  assign o_tx_data       = r_tx_data;
  assign o_tx_timeout    = r_tx_timeout;
  assign o_busy          = (r_state != IDLE) || !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !i_tx_active) begin
          w_launch    = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH:    w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (i_tx_done) begin
          w_state_nxt = GAP;
        end else if (r_wd == WD_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP:       w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_wd            <= '0;
      r_tx_data_valid <= 1'b0;
      r_tx_data       <= '0;
      r_tx_timeout    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_tx_data_valid <= w_launch;
      r_tx_timeout    <= w_timeout;
      if (w_launch) r_tx_data <= w_head;
      // Watchdog saturates rather than wrapping so a stuck count can never re-arm.
      if (r_state == LAUNCH) begin
        r_wd <= '0;
      end else if (r_state == WAIT_DONE && r_wd != '1) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a stub transmitter that answers launches with done.
// Short bit period keeps the watchdog scenario brief.
module tb_uart_tx_scheduler;

  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int CPB     = 4;
  localparam int TIMEOUT = 12 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full, empty, overflow;
  logic [4:0]    count;
  logic          tx_data_valid;
  logic [DW-1:0] tx_data;
  logic          tx_active = 1'b0;
  logic          tx_done = 1'b0;
  logic          tx_timeout;
  logic          busy;

  int n_pass = 0;
  int n_chk  = 0;
  int n_timeout = 0;
  int kick_cnt = 0;
  bit auto_done = 1'b0;
  logic [DW-1:0] launched [$];

  uart_tx_scheduler #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (TIMEOUT)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wr_en         (wr_en),
    .i_wr_data       (wr_data),
    .o_full          (full),
    .o_empty         (empty),
    .o_count         (count),
    .o_overflow      (overflow),
    .o_tx_data_valid (tx_data_valid),
    .o_tx_data       (tx_data),
    .i_tx_active     (tx_active),
    .i_tx_done       (tx_done),
    .o_tx_timeout    (tx_timeout),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_data_valid) launched.push_back(tx_data);
    if (tx_timeout) n_timeout++;
  end

  // Stub transmitter: pulses done two cycles after each launch, or on a kick request.
  initial begin
    int kick_seen;
    kick_seen = 0;
    forever begin
      @(negedge clk);
      if (tx_done) begin
        tx_done = 1'b0;
      end else if (auto_done && (tx_data_valid || kick_cnt != kick_seen)) begin
        kick_seen = kick_cnt;
        repeat (2) @(negedge clk);
        tx_done = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    tx_active = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_launches(input int target, input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (launched.size() < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, launched.size(), target);
  endtask

  initial begin
    int base;
    int tbase;
    int j;

    // Reset state
    do_reset();
    check("rst_valid", tx_data_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", tx_timeout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_data", tx_data, 0);

    // Single byte latency
    auto_done = 1'b1;
    tbase = n_timeout;
    wr_en = 1'b1; wr_data = 8'h3F;
    @(negedge clk);
    wr_en = 1'b0;
    check("t1_valid_k", tx_data_valid, 0);
    check("t1_count_k", count, 1);
    check("t1_busy_k", busy, 1);
    @(negedge clk);
    check("t1_valid_k1", tx_data_valid, 1);
    check("t1_data", tx_data, 8'h3F);
    check("t1_count_k1", count, 0);
    @(negedge clk);
    check("t1_valid_k2", tx_data_valid, 0);
    check("t1_data_hold", tx_data, 8'h3F);
    repeat (8) @(negedge clk);
    check("t1_busy_end", busy, 0);
    check("t1_no_timeout", n_timeout - tbase, 0);

    // Fill and overflow with done held low
    do_reset();
    auto_done = 1'b0;
    base = launched.size();
    tbase = n_timeout;
    for (int i = 0; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      @(negedge clk);
    end
    check("t2_count_full", count, 16);
    check("t2_full", full, 1);
    check("t2_first", launched.size() - base, 1);
    wr_data = 8'h11;
    @(negedge clk);
    wr_en = 1'b0;
    check("t2_overflow", overflow, 1);
    check("t2_count_ovf", count, 16);
    @(negedge clk);
    check("t2_overflow_clr", overflow, 0);
    auto_done = 1'b1;
    kick_cnt++;
    wait_launches(base + 17, 400, "t2_launch_cnt");
    for (int i = 0; i <= 16; i++) begin
      if (base + i < launched.size()) check("t2_order", launched[base + i], i);
    end
    check("t2_no_timeout", n_timeout - tbase, 0);

    // Simultaneous push and pop at count 3
    do_reset();
    auto_done = 1'b1;
    tx_active = 1'b1;
    base = launched.size();
    wr_en = 1'b1; wr_data = 8'hC1; @(negedge clk);
    wr_data = 8'hC2; @(negedge clk);
    wr_data = 8'hC3; @(negedge clk);
    check("t3_count3", count, 3);
    wr_data = 8'hC4; tx_active = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    check("t3_count_same", count, 3);
    check("t3_valid", tx_data_valid, 1);
    check("t3_pop_data", tx_data, 8'hC1);
    wait_launches(base + 4, 200, "t3_launch_cnt");
    if (launched.size() >= base + 4) begin
      check("t3_b", launched[base + 1], 8'hC2);
      check("t3_c", launched[base + 2], 8'hC3);
      check("t3_d", launched[base + 3], 8'hC4);
    end

    // Watchdog expiry with no done
    do_reset();
    auto_done = 1'b0;
    wr_en = 1'b1; wr_data = 8'hA1; @(negedge clk);
    wr_data = 8'hA2; @(negedge clk);
    wr_en = 1'b0;
    check("t4_launch", tx_data_valid, 1);
    j = 0;
    while (!tx_timeout && j < 200) begin
      @(negedge clk);
      j++;
    end
    check("t4_timeout_delay", j, TIMEOUT + 1);
    @(negedge clk);
    check("t4_timeout_pulse", tx_timeout, 0);
    j = 1;
    while (!tx_data_valid && j < 20) begin
      @(negedge clk);
      j++;
    end
    check("t4_relaunch_delay", j, 2);
    check("t4_relaunch_data", tx_data, 8'hA2);

    // Reset mid WAIT_DONE with 5 queued
    do_reset();
    auto_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = DW'(8'h50 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_count5", count, 5);
    #2;
    rst = 1'b1;
    #1;
    check("t5_empty", empty, 1);
    check("t5_count", count, 0);
    check("t5_busy", busy, 0);
    check("t5_data", tx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    base = launched.size();
    repeat (10) @(negedge clk);
    check("t5_no_launch", launched.size() - base, 0);

    // Transmitter still active blocks the launch
    do_reset();
    auto_done = 1'b1;
    tx_active = 1'b1;
    base = launched.size();
    wr_en = 1'b1; wr_data = 8'hD1; @(negedge clk);
    wr_data = 8'hD2; @(negedge clk);
    wr_en = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_held", launched.size() - base, 0);
    check("t6_count", count, 2);
    check("t6_busy", busy, 1);
    tx_active = 1'b0;
    @(negedge clk);
    check("t6_valid", tx_data_valid, 1);
    check("t6_data", tx_data, 8'hD1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
